alu_mc: RTL



---
 rtl/alu_mc_pkg.sv | 44 ++++
 rtl/alu_mc_comb.sv | 90 +++++++++
 rtl/alu_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode encoding, FSM state type and opcode classification helpers
// for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OPC_NEG  = 4'b0000,
    OPC_INC  = 4'b0001,
    OPC_ADD  = 4'b0010,
    OPC_ADDH = 4'b0011,
    OPC_AND  = 4'b0100,
    OPC_OR   = 4'b0101,
    OPC_CAT  = 4'b0110,
    OPC_SUB  = 4'b0111,
    OPC_MUL  = 4'b1000,
    OPC_SRA  = 4'b1001,
    OPC_SLL  = 4'b1010
  } opc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_multicycle(input logic [OPC_W-1:0] opc);
    logic mc_s;
    case (opc)
      OPC_MUL, OPC_SRA, OPC_SLL: mc_s = 1'b1;
      default:                   mc_s = 1'b0;
    endcase
    return mc_s;
  endfunction

  function automatic logic is_shift(input logic [OPC_W-1:0] opc);
    logic sh_s;
    case (opc)
      OPC_SRA, OPC_SLL: sh_s = 1'b1;
      default:          sh_s = 1'b0;
    endcase
    return sh_s;
  endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle ALU operations with carry/overflow generation. Shift opcodes
// here only cover the zero-shift case; the top iterates non-zero shifts.
module alu_mc_comb
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OPC_W-1:0] opc,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             inc,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic             sovf_s;

  // Operand selection for the shared adder: every arithmetic op is a + b + cin.
  always_comb begin
    opa_s = ina;
    opb_s = {WIDTH{1'b0}};
    cin_s = 1'b0;
    case (opc)
      OPC_NEG: begin
        opa_s = ~ina;
        cin_s = 1'b1;
      end
      OPC_INC: begin
        cin_s = 1'b1;
      end
      OPC_ADD: begin
        opb_s = inb;
        cin_s = inc;
      end
      OPC_ADDH: begin
        opb_s = {inb[WIDTH-1], inb[WIDTH-1:1]};
      end
      OPC_SUB: begin
        opb_s = ~inb;
        cin_s = 1'b1;
      end
      default: begin
        opa_s = ina;
        opb_s = {WIDTH{1'b0}};
        cin_s = 1'b0;
      end
    endcase
  end

  // Shared adder and signed-overflow detector on the effective operands.
  always_comb begin
    sum_s  = {1'b0, opa_s} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin_s};
    sovf_s = (opa_s[WIDTH-1] == opb_s[WIDTH-1]) && (sum_s[WIDTH-1] != opa_s[WIDTH-1]);
  end

  // Result and flag selection per opcode; illegal opcodes give all zeros.
  always_comb begin
    res  = {WIDTH{1'b0}};
    cout = 1'b0;
    ovf  = 1'b0;
    case (opc)
      OPC_NEG, OPC_INC: begin
        res  = sum_s[WIDTH-1:0];
        cout = sum_s[WIDTH];
      end
      OPC_ADD, OPC_ADDH, OPC_SUB: begin
        res  = sum_s[WIDTH-1:0];
        cout = sum_s[WIDTH];
        ovf  = sovf_s;
      end
      OPC_AND: res = ina & inb;
      OPC_OR:  res = ina | inb;
      OPC_CAT: res = {ina[HW-1:0], inb[HW-1:0]};
      OPC_SRA, OPC_SLL: res = ina;
      default: begin
        res  = {WIDTH{1'b0}};
        cout = 1'b0;
        ovf  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops through alu_mc_comb, iterative
// shift-add multiply and one-bit-per-cycle shifts, with start/busy/done.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPC_W-1:0] opc,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             inc,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // Counter must hold both WIDTH (multiply) and the largest shift amount.
  localparam int CWM = $clog2(WIDTH + 1);
  localparam int CW  = (CWM > SHW) ? CWM : SHW;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e           state_r;
  logic [OPC_W-1:0] op_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mpa_r;
  logic [WIDTH-1:0] mpb_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] comb_res_s;
  logic             comb_cout_s;
  logic             comb_ovf_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [SHW-1:0]   shamt_s;

  assign shamt_s = inb[SHW-1:0];

  alu_mc_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .opc  (opc),
    .ina  (ina),
    .inb  (inb),
    .inc  (inc),
    .res  (comb_res_s),
    .cout (comb_cout_s),
    .ovf  (comb_ovf_s)
  );

  // One iteration of the running multi-cycle operation.
  always_comb begin
    acc_nxt_s = acc_r;
    case (op_r)
      OPC_MUL: begin
        if (mpb_r[0]) begin
          acc_nxt_s = acc_r + mpa_r;
        end else begin
          acc_nxt_s = acc_r;
        end
      end
      OPC_SRA: acc_nxt_s = {acc_r[WIDTH-1], acc_r[WIDTH-1:1]};
      OPC_SLL: acc_nxt_s = {acc_r[WIDTH-2:0], 1'b0};
      default: acc_nxt_s = acc_r;
    endcase
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= {OPC_W{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      mpa_r   <= {WIDTH{1'b0}};
      mpb_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      w       <= {WIDTH{1'b0}};
      zer     <= 1'b0;
      neg     <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (opc == OPC_MUL) begin
              state_r <= ST_RUN;
              op_r    <= opc;
              cnt_r   <= CW'(WIDTH);
              acc_r   <= {WIDTH{1'b0}};
              mpa_r   <= ina;
              mpb_r   <= inb;
              busy    <= 1'b1;
            end else if (is_shift(opc) && (shamt_s != {SHW{1'b0}})) begin
              state_r <= ST_RUN;
              op_r    <= opc;
              cnt_r   <= CW'(shamt_s);
              acc_r   <= ina;
              busy    <= 1'b1;
            end else begin
              w    <= comb_res_s;
              zer  <= (comb_res_s == {WIDTH{1'b0}});
              neg  <= comb_res_s[WIDTH-1];
              cout <= comb_cout_s;
              ovf  <= comb_ovf_s;
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          acc_r <= acc_nxt_s;
          mpa_r <= {mpa_r[WIDTH-2:0], 1'b0};
          mpb_r <= {1'b0, mpb_r[WIDTH-1:1]};
          cnt_r <= cnt_r - CNT_ONE;
          // Only the finished value reaches w; partial results stay in acc_r.
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            w       <= acc_nxt_s;
            zer     <= (acc_nxt_s == {WIDTH{1'b0}});
            neg     <= acc_nxt_s[WIDTH-1];
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
